// File: rtl/acia_rx_fifo.sv
// ACIA receive FIFO: captures receiver bytes plus error flags into a
// show-ahead FIFO that the CPU pops.
module acia_rx_fifo #(
    parameter int DEPTH  = 16,
    parameter int THRESH = 8
) (
    input  logic                     PHI2,
    input  logic                     RESET,
    input  logic [7:0]               RXDATA_IN,
    input  logic                     RXFULL_IN,
    input  logic                     FRAME_IN,
    input  logic                     PARITY_IN,
    input  logic                     OVERFLOW_IN,
    output logic                     RXTAKEN,
    input  logic                     RD,
    output logic [7:0]               DOUT,
    output logic [2:0]               DSTAT,
    output logic                     EMPTY,
    output logic                     FULL,
    output logic [$clog2(DEPTH):0]   COUNT,
    output logic                     LEVEL
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACK  = 2'd1,
        WAIT = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [AW-1:0]   wptr_q, wptr_d;
    logic [AW-1:0]   rptr_q, rptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic            rxtaken_q, rxtaken_d;
    logic [10:0]     mem_q [DEPTH];
    logic [10:0]     head;
    logic            wr_en;
    logic            rd_en;

    assign EMPTY = (count_q == '0);
    assign FULL  = (count_q == CW'(DEPTH));
    assign LEVEL = (count_q >= CW'(THRESH));
    assign COUNT = count_q;
    assign RXTAKEN = rxtaken_q;

    // Show-ahead head entry, forced to zero when nothing is stored
    assign head  = mem_q[rptr_q];
    assign DOUT  = EMPTY ? 8'h00 : head[10:3];
    assign DSTAT = EMPTY ? 3'b000 : head[2:0];

    assign rd_en = RD && !EMPTY;

    always_comb begin
        state_d   = state_q;
        wr_en     = 1'b0;
        rxtaken_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                // A pop in the same cycle frees a slot for a full FIFO
                if (RXFULL_IN && (!FULL || RD)) begin
                    wr_en     = 1'b1;
                    rxtaken_d = 1'b1;
                    state_d   = ACK;
                end
            end
            ACK:  state_d = WAIT;
            WAIT: begin
                if (!RXFULL_IN) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        wptr_d  = wr_en ? wptr_q + AW'(1) : wptr_q;
        rptr_d  = rd_en ? rptr_q + AW'(1) : rptr_q;
        count_d = count_q + CW'(wr_en) - CW'(rd_en);
    end

    always_ff @(posedge PHI2) begin
        if (RESET) begin
            state_q   <= IDLE;
            wptr_q    <= '0;
            rptr_q    <= '0;
            count_q   <= '0;
            rxtaken_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            wptr_q    <= wptr_d;
            rptr_q    <= rptr_d;
            count_q   <= count_d;
            rxtaken_q <= rxtaken_d;
        end
    end

    always_ff @(posedge PHI2) begin
        if (!RESET && wr_en) begin
            mem_q[wptr_q] <= {RXDATA_IN, FRAME_IN, PARITY_IN, OVERFLOW_IN};
        end
    end

endmodule

// File: tb/tb_acia_rx_fifo.sv
// Directed self-checking bench for acia_rx_fifo.
module tb_acia_rx_fifo;

    logic       PHI2;
    logic       RESET;
    logic [7:0] RXDATA_IN;
    logic       RXFULL_IN;
    logic       FRAME_IN;
    logic       PARITY_IN;
    logic       OVERFLOW_IN;
    logic       RXTAKEN;
    logic       RD;
    logic [7:0] DOUT;
    logic [2:0] DSTAT;
    logic       EMPTY;
    logic       FULL;
    logic [4:0] COUNT;
    logic       LEVEL;

    int checks;
    int failures;

    acia_rx_fifo #(.DEPTH(16), .THRESH(8)) dut (
        .PHI2        (PHI2),
        .RESET       (RESET),
        .RXDATA_IN   (RXDATA_IN),
        .RXFULL_IN   (RXFULL_IN),
        .FRAME_IN    (FRAME_IN),
        .PARITY_IN   (PARITY_IN),
        .OVERFLOW_IN (OVERFLOW_IN),
        .RXTAKEN     (RXTAKEN),
        .RD          (RD),
        .DOUT        (DOUT),
        .DSTAT       (DSTAT),
        .EMPTY       (EMPTY),
        .FULL        (FULL),
        .COUNT       (COUNT),
        .LEVEL       (LEVEL)
    );

    initial PHI2 = 1'b0;
    always #5 PHI2 = ~PHI2;

    task automatic tick();
        @(posedge PHI2);
        #1;
    endtask

    task automatic pop();
        RD = 1'b1;
        tick();
        RD = 1'b0;
    endtask

    // Receiver model: raise RXFULL, wait for the ack, drop RXFULL, let FSM return to IDLE
    task automatic send_byte(input logic [7:0] d, input logic f,
                             input logic p, input logic o);
        int n;
        RXDATA_IN   = d;
        FRAME_IN    = f;
        PARITY_IN   = p;
        OVERFLOW_IN = o;
        RXFULL_IN   = 1'b1;
        n = 0;
        do begin
            tick();
            n++;
        end while (RXTAKEN !== 1'b1 && n < 40);
        checks++;
        if (RXTAKEN !== 1'b1) begin
            failures++;
            $display("FAIL send_timeout data=%h rxtaken=%b expected=1", d, RXTAKEN);
        end
        RXFULL_IN = 1'b0;
        tick();
        tick();
    endtask

    task automatic test_reset();
        RESET = 1'b1;
        tick();
        tick();
        RESET = 1'b0;
        checks++;
        if ({EMPTY, FULL, LEVEL, RXTAKEN} !== 4'b1000) begin
            failures++;
            $display("FAIL reset_flags got=%b expected=1000", {EMPTY, FULL, LEVEL, RXTAKEN});
        end
        checks++;
        if (COUNT !== 5'd0) begin
            failures++;
            $display("FAIL reset_count got=%0d expected=0", COUNT);
        end
        checks++;
        if ({DOUT, DSTAT} !== 11'd0) begin
            failures++;
            $display("FAIL reset_dout got=%h/%b expected=00/000", DOUT, DSTAT);
        end
    endtask

    task automatic test_single();
        RXDATA_IN = 8'hA5;
        {FRAME_IN, PARITY_IN, OVERFLOW_IN} = 3'b000;
        RXFULL_IN = 1'b1;
        tick();
        checks++;
        if ({RXTAKEN, EMPTY, COUNT} !== {1'b1, 1'b0, 5'd1}) begin
            failures++;
            $display("FAIL single_capture got tk=%b em=%b cnt=%0d expected tk=1 em=0 cnt=1",
                     RXTAKEN, EMPTY, COUNT);
        end
        checks++;
        if (DOUT !== 8'hA5) begin
            failures++;
            $display("FAIL single_dout got=%h expected=a5", DOUT);
        end
        tick();
        checks++;
        if (RXTAKEN !== 1'b0) begin
            failures++;
            $display("FAIL single_ack_width got=%b expected=0", RXTAKEN);
        end
        tick();
        tick();
        checks++;
        if (COUNT !== 5'd1 || RXTAKEN !== 1'b0) begin
            failures++;
            $display("FAIL single_no_recapture got cnt=%0d tk=%b expected cnt=1 tk=0", COUNT, RXTAKEN);
        end
        RXFULL_IN = 1'b0;
        tick();
        pop();
        checks++;
        if ({EMPTY, DOUT} !== {1'b1, 8'h00}) begin
            failures++;
            $display("FAIL single_pop got em=%b dout=%h expected em=1 dout=00", EMPTY, DOUT);
        end
    endtask

    task automatic test_status();
        send_byte(8'h3C, 1'b1, 1'b0, 1'b1);
        checks++;
        if ({DOUT, DSTAT} !== {8'h3C, 3'b101}) begin
            failures++;
            $display("FAIL status_head got=%h/%b expected=3c/101", DOUT, DSTAT);
        end
        pop();
        checks++;
        if ({EMPTY, DSTAT} !== {1'b1, 3'b000}) begin
            failures++;
            $display("FAIL status_pop got em=%b st=%b expected em=1 st=000", EMPTY, DSTAT);
        end
    endtask

    task automatic test_fill();
        logic exp_level;
        for (int i = 0; i < 16; i++) begin
            send_byte(8'(i), 1'b0, 1'b0, 1'b0);
            exp_level = (i + 1 >= 8);
            checks++;
            if (LEVEL !== exp_level) begin
                failures++;
                $display("FAIL fill_level n=%0d got=%b expected=%b", i + 1, LEVEL, exp_level);
            end
        end
        checks++;
        if ({FULL, COUNT} !== {1'b1, 5'd16}) begin
            failures++;
            $display("FAIL fill_full got full=%b cnt=%0d expected full=1 cnt=16", FULL, COUNT);
        end
        RXDATA_IN = 8'h11;
        RXFULL_IN = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (RXTAKEN !== 1'b0 || COUNT !== 5'd16) begin
                failures++;
                $display("FAIL fill_stall got tk=%b cnt=%0d expected tk=0 cnt=16", RXTAKEN, COUNT);
            end
        end
        checks++;
        if (DOUT !== 8'h00) begin
            failures++;
            $display("FAIL fill_head got=%h expected=00", DOUT);
        end
        RD = 1'b1;
        tick();
        RD = 1'b0;
        checks++;
        if ({RXTAKEN, COUNT, DOUT} !== {1'b1, 5'd16, 8'h01}) begin
            failures++;
            $display("FAIL fill_pop_capture got tk=%b cnt=%0d dout=%h expected tk=1 cnt=16 dout=01",
                     RXTAKEN, COUNT, DOUT);
        end
        RXFULL_IN = 1'b0;
        tick();
        tick();
        for (int j = 1; j < 16; j++) begin
            checks++;
            if (DOUT !== 8'(j)) begin
                failures++;
                $display("FAIL fill_order got=%h expected=%h", DOUT, 8'(j));
            end
            pop();
        end
        checks++;
        if (DOUT !== 8'h11) begin
            failures++;
            $display("FAIL fill_last got=%h expected=11", DOUT);
        end
        pop();
        checks++;
        if (EMPTY !== 1'b1) begin
            failures++;
            $display("FAIL fill_drain got em=%b expected=1", EMPTY);
        end
    endtask

    task automatic test_simultaneous();
        for (int i = 0; i < 5; i++) send_byte(8'h50 + 8'(i), 1'b0, 1'b0, 1'b0);
        checks++;
        if (COUNT !== 5'd5) begin
            failures++;
            $display("FAIL simul_pre got=%0d expected=5", COUNT);
        end
        RXDATA_IN = 8'h55;
        RXFULL_IN = 1'b1;
        RD = 1'b1;
        tick();
        RD = 1'b0;
        checks++;
        if ({COUNT, RXTAKEN, DOUT} !== {5'd5, 1'b1, 8'h51}) begin
            failures++;
            $display("FAIL simul_both got cnt=%0d tk=%b dout=%h expected cnt=5 tk=1 dout=51",
                     COUNT, RXTAKEN, DOUT);
        end
        RXFULL_IN = 1'b0;
        tick();
        tick();
        for (int j = 1; j < 6; j++) begin
            checks++;
            if (DOUT !== 8'h50 + 8'(j)) begin
                failures++;
                $display("FAIL simul_order got=%h expected=%h", DOUT, 8'h50 + 8'(j));
            end
            pop();
        end
        pop();
        checks++;
        if ({COUNT, EMPTY} !== {5'd0, 1'b1}) begin
            failures++;
            $display("FAIL simul_empty_rd got cnt=%0d em=%b expected cnt=0 em=1", COUNT, EMPTY);
        end
        RXDATA_IN = 8'h66;
        RXFULL_IN = 1'b1;
        RD = 1'b1;
        tick();
        RD = 1'b0;
        checks++;
        if ({COUNT, DOUT} !== {5'd1, 8'h66}) begin
            failures++;
            $display("FAIL simul_empty_wr got cnt=%0d dout=%h expected cnt=1 dout=66", COUNT, DOUT);
        end
        RXFULL_IN = 1'b0;
        tick();
        tick();
        pop();
    endtask

    task automatic test_wrap();
        logic [7:0] q[$];
        logic [7:0] d;
        logic [7:0] exp;
        for (int i = 0; i < 40; i++) begin
            d = 8'(i * 37 + 5);
            send_byte(d, 1'b0, 1'b0, 1'b0);
            q.push_back(d);
            checks++;
            if (FULL !== 1'b0) begin
                failures++;
                $display("FAIL wrap_full i=%0d got=%b expected=0", i, FULL);
            end
            if (q.size() == 3 || i == 39) begin
                while (q.size() > 0) begin
                    exp = q.pop_front();
                    checks++;
                    if (DOUT !== exp) begin
                        failures++;
                        $display("FAIL wrap_order i=%0d got=%h expected=%h", i, DOUT, exp);
                    end
                    pop();
                end
            end
        end
        checks++;
        if ({EMPTY, COUNT} !== {1'b1, 5'd0}) begin
            failures++;
            $display("FAIL wrap_end got em=%b cnt=%0d expected em=1 cnt=0", EMPTY, COUNT);
        end
    endtask

    task automatic test_reset_wait();
        RXDATA_IN = 8'h77;
        RXFULL_IN = 1'b1;
        tick();
        tick();
        RESET = 1'b1;
        tick();
        RESET = 1'b0;
        checks++;
        if ({COUNT, RXTAKEN, EMPTY} !== {5'd0, 1'b0, 1'b1}) begin
            failures++;
            $display("FAIL rstwait_clear got cnt=%0d tk=%b em=%b expected cnt=0 tk=0 em=1",
                     COUNT, RXTAKEN, EMPTY);
        end
        tick();
        checks++;
        if ({COUNT, RXTAKEN, DOUT} !== {5'd1, 1'b1, 8'h77}) begin
            failures++;
            $display("FAIL rstwait_recapture got cnt=%0d tk=%b dout=%h expected cnt=1 tk=1 dout=77",
                     COUNT, RXTAKEN, DOUT);
        end
        tick();
        tick();
        tick();
        checks++;
        if (COUNT !== 5'd1) begin
            failures++;
            $display("FAIL rstwait_once got=%0d expected=1", COUNT);
        end
        RXFULL_IN = 1'b0;
        tick();
        tick();
    endtask

    task automatic test_reset_override();
        send_byte(8'hE1, 1'b0, 1'b0, 1'b0);
        checks++;
        if (COUNT !== 5'd2) begin
            failures++;
            $display("FAIL rstovr_pre got=%0d expected=2", COUNT);
        end
        RXDATA_IN = 8'h99;
        RXFULL_IN = 1'b1;
        RD = 1'b1;
        RESET = 1'b1;
        tick();
        RESET = 1'b0;
        RD = 1'b0;
        RXFULL_IN = 1'b0;
        checks++;
        if ({COUNT, EMPTY, RXTAKEN, DOUT} !== {5'd0, 1'b1, 1'b0, 8'h00}) begin
            failures++;
            $display("FAIL rstovr got cnt=%0d em=%b tk=%b dout=%h expected cnt=0 em=1 tk=0 dout=00",
                     COUNT, EMPTY, RXTAKEN, DOUT);
        end
        tick();
        checks++;
        if (COUNT !== 5'd0) begin
            failures++;
            $display("FAIL rstovr_after got=%0d expected=0", COUNT);
        end
    endtask

    initial begin
        checks      = 0;
        failures    = 0;
        RESET       = 1'b1;
        RXDATA_IN   = 8'h00;
        RXFULL_IN   = 1'b0;
        FRAME_IN    = 1'b0;
        PARITY_IN   = 1'b0;
        OVERFLOW_IN = 1'b0;
        RD          = 1'b0;
        test_reset();
        test_single();
        test_status();
        test_fill();
        test_simultaneous();
        test_wrap();
        test_reset_wait();
        test_reset_override();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
